// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx among N_REQ byte sources.
// An owner keeps the transmitter for a burst until req_last, req drop or MAX_BURST bytes.
module uart_tx_arb #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*PAYLOAD_BITS-1:0]   req_data,
  input  logic [N_REQ-1:0]                req_last,
  output logic [N_REQ-1:0]                ack,
  output logic [IDX_W-1:0]                owner,
  output logic                            owner_valid,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [IDX_W-1:0] next_owner;
  logic [CntW-1:0]  burst_q, burst_d;
  logic             last_flag_q, last_flag_d;
  logic             send;

  // Descending scan so the candidate closest after last_owner_q wins.
  always_comb begin
    next_owner = last_owner_q;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      if (req[IDX_W'((int'(last_owner_q) + k) % int'(N_REQ))]) begin
        next_owner = IDX_W'((int'(last_owner_q) + k) % int'(N_REQ));
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    last_flag_d  = last_flag_q;
    send         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = next_owner;
          burst_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!req[owner_q]) begin
          last_owner_d = owner_q;
          state_d      = StIdle;
        end else if (!uart_tx_busy) begin
          send        = 1'b1;
          last_flag_d = req_last[owner_q];
          burst_d     = burst_q + 1'b1;
          state_d     = StWaitBusy;
        end
      end
      // Hold off until uart_tx shows it has taken the byte.
      StWaitBusy: begin
        if (uart_tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          if (last_flag_q || (burst_q == CntW'(MAX_BURST))) begin
            last_owner_d = owner_q;
            state_d      = StIdle;
          end else begin
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      burst_q      <= '0;
      last_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      last_flag_q  <= last_flag_d;
    end
  end

  always_comb begin
    uart_tx_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (owner_q == IDX_W'(i)) uart_tx_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  always_comb begin
    ack = '0;
    if (send) ack[owner_q] = 1'b1;
  end

  assign uart_tx_en  = send;
  assign owner       = owner_q;
  assign owner_valid = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small uart_tx busy model and byte-source model.
module tb_uart_tx_arb;

  localparam int N     = 4;
  localparam int PB    = 8;
  localparam int MB    = 4;
  localparam int FRAME = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req, req_last, ack;
  logic [N*PB-1:0] req_data;
  logic [1:0]      owner;
  logic            owner_valid, uart_tx_en, uart_tx_busy;
  logic [PB-1:0]   uart_tx_data;

  // Source model: bytes remaining, next byte, last mode (0 never, 1 final byte, 2 every byte)
  int            rem   [N];
  logic [PB-1:0] nxt   [N];
  int            lmode [N];
  int            busy_cnt;
  logic          force_busy;

  logic          s_en, s_ov;
  logic [N-1:0]  s_ack;
  logic [1:0]    s_owner;
  logic [PB-1:0] s_data;

  logic [1:0]    log_own[$];
  logic [PB-1:0] log_dat[$];

  int errors = 0;
  int checks = 0;

  int            exp4_own [12] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 0, 3, 3};
  logic [PB-1:0] exp4_dat [12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'hB0, 8'h34,
                                   8'h35, 8'h36, 8'h37, 8'hB1, 8'h38, 8'h39};

  uart_tx_arb #(
    .N_REQ       (N),
    .PAYLOAD_BITS(PB),
    .MAX_BURST   (MB),
    .IDX_W       (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .owner       (owner),
    .owner_valid (owner_valid),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]              = (rem[i] > 0);
      req_data[i*PB +: PB] = nxt[i];
      req_last[i]         = (lmode[i] == 2) || (lmode[i] == 1 && rem[i] == 1);
    end
    uart_tx_busy = (busy_cnt > 0) || force_busy;
  endtask

  // One clock: sample at negedge, then update the models just after posedge.
  task automatic cycle();
    @(negedge clk);
    s_en    = uart_tx_en;
    s_ack   = ack;
    s_ov    = owner_valid;
    s_owner = owner;
    s_data  = uart_tx_data;
    if (s_en) begin
      check("en_while_busy", 32'(uart_tx_busy), 0);
      check("ack_onehot", 32'(s_ack), 32'd1 << s_owner);
      log_own.push_back(s_owner);
      log_dat.push_back(s_data);
    end else begin
      check("ack_without_en", 32'(s_ack), 0);
    end
    @(posedge clk);
    #1;
    if (s_en) busy_cnt = FRAME;
    else if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < N; i++) begin
      if (s_ack[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    end
    drive();
  endtask

  task automatic run_quiet(input string tag, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle();
      if (req == '0 && !owner_valid && busy_cnt == 0) done = 1'b1;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    force_busy = 1'b0;
    busy_cnt   = 0;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      nxt[i]   = '0;
      lmode[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    log_own.delete();
    log_dat.delete();
  endtask

  task automatic load(input int i, input int n, input logic [PB-1:0] d, input int m);
    rem[i]   = n;
    nxt[i]   = d;
    lmode[i] = m;
    drive();
  endtask

  initial begin
    // Reset values
    resetn = 1'b0;
    force_busy = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; nxt[i] = '0; lmode[i] = 0;
    end
    drive();
    #3;
    check("rst_owner_valid", 32'(owner_valid), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_en", 32'(uart_tx_en), 0);

    // Single byte from requester 2
    do_reset();
    load(2, 1, 8'h5A, 1);
    cycle();
    check("t1_en_same_cycle", 32'(s_en), 0);
    cycle();
    check("t1_en", 32'(s_en), 1);
    check("t1_ack", 32'(s_ack), 32'b0100);
    check("t1_data", 32'(s_data), 32'h5A);
    check("t1_owner", 32'(s_owner), 2);
    run_quiet("t1_quiet", 40);
    check("t1_idle", 32'(owner_valid), 0);
    check("t1_count", log_own.size(), 1);

    // Round-robin, every byte is a burst end
    do_reset();
    for (int i = 0; i < N; i++) load(i, 2, 8'(8'h20 + 8'h10 * i), 2);
    run_quiet("t2_quiet", 200);
    check("t2_count", log_own.size(), 8);
    for (int j = 0; j < 8 && j < log_own.size(); j++) begin
      check("t2_owner", 32'(log_own[j]), j % 4);
      check("t2_data", 32'(log_dat[j]), 32'h20 + 32'h10 * (j % 4) + j / 4);
    end

    // Three-byte burst from requester 1 while requester 0 waits
    do_reset();
    load(1, 3, 8'h10, 1);
    cycle();
    load(0, 1, 8'hA0, 1);
    run_quiet("t3_quiet", 100);
    check("t3_count", log_own.size(), 4);
    for (int j = 0; j < 4 && j < log_own.size(); j++) begin
      check("t3_owner", 32'(log_own[j]), (j < 3) ? 1 : 0);
      check("t3_data", 32'(log_dat[j]), (j < 3) ? 32'h10 + j : 32'hA0);
    end

    // MAX_BURST cut: requester 3 streams 10 bytes, requester 0 interleaves
    do_reset();
    load(3, 10, 8'h30, 0);
    cycle();
    load(0, 2, 8'hB0, 2);
    run_quiet("t4_quiet", 300);
    check("t4_count", log_own.size(), 12);
    for (int j = 0; j < 12 && j < log_own.size(); j++) begin
      check("t4_owner", 32'(log_own[j]), exp4_own[j]);
      check("t4_data", 32'(log_dat[j]), 32'(exp4_dat[j]));
    end

    // Withdrawal while transmitter still busy
    do_reset();
    force_busy = 1'b1;
    load(1, 1, 8'h77, 1);
    cycle();
    cycle();
    check("t5_hold_owner", 32'(s_owner), 1);
    check("t5_hold_ov", 32'(s_ov), 1);
    check("t5_hold_en", 32'(s_en), 0);
    rem[1] = 0;
    load(2, 1, 8'hC0, 1);
    cycle();
    cycle();
    check("t5_released", 32'(s_ov), 0);
    cycle();
    check("t5_next_owner", 32'(s_owner), 2);
    check("t5_next_ov", 32'(s_ov), 1);
    force_busy = 1'b0;
    drive();
    run_quiet("t5_quiet", 60);
    check("t5_count", log_own.size(), 1);
    if (log_own.size() > 0) begin
      check("t5_owner", 32'(log_own[0]), 2);
      check("t5_data", 32'(log_dat[0]), 32'hC0);
    end

    // Reset during WAIT_DONE of requester 3's tenure
    do_reset();
    load(2, 1, 8'h40, 1);
    load(3, 1, 8'h50, 1);
    for (int n = 0; n < 60 && log_own.size() < 2; n++) cycle();
    check("t6_two_grants", log_own.size(), 2);
    cycle();
    cycle();
    check("t6_pre_ov", 32'(owner_valid), 1);
    check("t6_pre_owner", 32'(owner), 3);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_ov", 32'(owner_valid), 0);
    check("t6_rst_en", 32'(uart_tx_en), 0);
    check("t6_rst_ack", 32'(ack), 0);
    busy_cnt = 0;
    log_own.delete();
    log_dat.delete();
    load(0, 1, 8'hD0, 1);
    load(3, 1, 8'hE0, 1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run_quiet("t6_quiet", 80);
    check("t6_count", log_own.size(), 2);
    if (log_own.size() == 2) begin
      check("t6_first", 32'(log_own[0]), 0);
      check("t6_second", 32'(log_own[1]), 3);
      check("t6_first_data", 32'(log_dat[0]), 32'hD0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares the single uart_tx transmitter between N_REQ independent byte sources.
- Each source requests the transmitter and streams bytes while it holds ownership.
- Ownership is granted round-robin and held for a burst, terminated by req_last, req drop or MAX_BURST.
- Sits between the application producers and uart_tx, replacing direct uart_tx_en/uart_tx_data drive.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- PAYLOAD_BITS, 8: byte width; must match uart_tx.
- MAX_BURST, 16: maximum bytes per ownership tenure (>=1).
- IDX_W, 2: owner index width; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester "byte available"; held high until ack.
- req_data  input  N_REQ*PAYLOAD_BITS  requester i byte at [i*PAYLOAD_BITS +: PAYLOAD_BITS]; stable while req[i] is high.
- req_last  input  N_REQ  qualifies the current byte as the final byte of the burst.
- ack  output  N_REQ  one-cycle pulse, one-hot: byte of requester i accepted.
- owner  output  IDX_W  index of the current owner.
- owner_valid  output  1  ownership held (state != IDLE).
- uart_tx_en  output  1  to uart_tx enable.
- uart_tx_data  output  PAYLOAD_BITS  to uart_tx data.
- uart_tx_busy  input  1  from uart_tx; rises the cycle after an accepted enable and falls at end of the stop bit.

Behaviour:
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- Reset values: state=IDLE; owner=0; owner_valid=0; ack=0; uart_tx_en=0; burst count=0; last_owner=N_REQ-1, so requester 0 has first priority.
- IDLE: if any req is high, register owner as the first set bit searching from (last_owner+1) mod N_REQ, wrapping. Clear burst count and go to ISSUE. If no req is high, stay in IDLE.
- ISSUE, req[owner]=1 and uart_tx_busy=0:
  - uart_tx_en=1 and ack[owner]=1 in the same cycle (combinational from registered state).
  - uart_tx_data = owner slice of req_data; registered last_flag<=req_last[owner]; burst count +1.
  - Next state WAIT_BUSY.
- ISSUE, req[owner]=0: release. Next state IDLE, last_owner<=owner, nothing sent.
- ISSUE, busy high: hold in ISSUE; uart_tx_en stays low.
- uart_tx_en is never high outside ISSUE; uart_tx_data is don't-care when uart_tx_en=0 but drives the owner slice.
- WAIT_BUSY: wait for uart_tx_busy=1, then go to WAIT_DONE. The intent is that uart_tx_en is never reissued before uart_tx has registered the byte.
- WAIT_DONE: wait for uart_tx_busy=0, then:
  - release (IDLE, last_owner<=owner) if last_flag=1 or burst count==MAX_BURST;
  - else go to ISSUE.
- Latency: req rising in IDLE with transmitter idle -> ack/uart_tx_en exactly 1 cycle later.
- Fairness: after release, the releasing requester has lowest priority; no requester waits more than N_REQ-1 tenures.
- Req of a non-owner during a tenure is ignored until IDLE.
- Simultaneous req_last and MAX_BURST: single release.
- MAX_BURST=1 degenerates to byte-level round-robin.
- Asynchronous reset mid-frame: immediate return to reset values. The arbiter does not retransmit; uart_tx is reset by the same resetn.
- Burst counter width: clog2(MAX_BURST+1); never wraps.

Test Plan:
- Single byte: req[2]=1, req_data slice 2=8'h5A, req_last[2]=1, busy low.
  - -> ack=4'b0100 and uart_tx_en=1 with data 8'h5A one cycle later.
  - -> owner=2; IDLE after busy falls.
- Round-robin: req=4'b1111, all req_last=1 from reset.
  - -> grant order 0,1,2,3,0.
  - -> exactly one ack per uart_tx frame; no uart_tx_en while busy high.
- Burst: requester 1 sends 3 bytes 8'h10,8'h11,8'h12 with req_last on the third; req[0] is also high throughout.
  - -> all 3 bytes sent back-to-back with owner=1.
  - -> requester 0 granted only afterwards.
- MAX_BURST cut: MAX_BURST=4, requester 3 streams 10 bytes with no req_last, requester 0 also requesting.
  - -> after 4 acks, owner switches to 0.
  - -> requester 3 resumes after requester 0's tenure.
- Withdrawal: grant to requester 1, then req[1] drops while busy is still high from the prior byte.
  - -> no ack, no uart_tx_en.
  - -> IDLE, next grant to requester 2 if requesting.
- Reset mid-frame: resetn low during WAIT_DONE.
  - -> same cycle owner_valid=0, uart_tx_en=0, ack=0.
  - -> after release, first grant goes to requester 0.
